// File: rtl/plic_target_ctrl.sv
// PLIC target controller: source gateways, pending/in-service tracking and the claim/complete handshake.
// Optional build macro PLIC_EDGE_TRIG_EN adds src_edge_i for per-source rising-edge triggering.
module plic_target_ctrl #(
    parameter int NUM_IRQ  = 32,
    parameter int PRIO_BIT = 3,
    parameter int ID_WIDTH = 6
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_IRQ-1:0]  src_irq_i,
`ifdef PLIC_EDGE_TRIG_EN
    input  logic [NUM_IRQ-1:0]  src_edge_i,
`endif
    output logic [NUM_IRQ-1:0]  pend_o,
    input  logic                arb_irq_i,
    input  logic [ID_WIDTH-1:0] arb_id_i,
    input  logic [PRIO_BIT-1:0] arb_pri_i,
    input  logic [PRIO_BIT-1:0] threshold_i,
    output logic                eip_o,
    input  logic                claim_req_i,
    output logic                claim_ack_o,
    output logic [ID_WIDTH-1:0] claim_id_o,
    input  logic                cmpl_req_i,
    input  logic [ID_WIDTH-1:0] cmpl_id_i,
    output logic                cmpl_ack_o
);

    typedef enum logic [1:0] {IDLE, CLAIM, SETTLE, CMPL} state_t;

    state_t              state_q;
    logic [NUM_IRQ-1:0]  pending_q;
    logic [NUM_IRQ-1:0]  inservice_q;
    logic [NUM_IRQ-1:0]  trig;
    logic [NUM_IRQ-1:0]  set_mask;
    logic [NUM_IRQ-1:0]  claim_hit;
    logic [NUM_IRQ-1:0]  cmpl_hit;
    logic [ID_WIDTH-1:0] best_id_q;
    logic [ID_WIDTH-1:0] cmpl_id_q;
    logic                eip_q;

`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_IRQ-1:0]  src_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            src_prev_q <= '0;
        end else begin
            src_prev_q <= src_irq_i;
        end
    end

    assign trig = (src_irq_i & ~src_edge_i) | (src_irq_i & ~src_prev_q & src_edge_i);
`else
    assign trig = src_irq_i;
`endif

    // A source may only raise a new request once its previous one is fully retired.
    assign set_mask = trig & ~pending_q & ~inservice_q;

    always_comb begin
        claim_hit = '0;
        cmpl_hit  = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            claim_hit[k] = (state_q == CLAIM) && (claim_id_o == ID_WIDTH'(k + 1));
            cmpl_hit[k]  = (state_q == CMPL) && (cmpl_id_q == ID_WIDTH'(k + 1)) && inservice_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pending_q   <= '0;
            inservice_q <= '0;
            best_id_q   <= '0;
            eip_q       <= 1'b0;
        end else begin
            pending_q   <= (pending_q | set_mask) & ~claim_hit;
            inservice_q <= (inservice_q | claim_hit) & ~cmpl_hit;
            best_id_q   <= arb_id_i;
            eip_q       <= arb_irq_i && (arb_pri_i > threshold_i);
        end
    end

    // SETTLE gives the arbiter one cycle to see the cleared pending bit before the next claim.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            claim_ack_o <= 1'b0;
            claim_id_o  <= '0;
            cmpl_ack_o  <= 1'b0;
            cmpl_id_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (claim_req_i) begin
                        state_q     <= CLAIM;
                        claim_ack_o <= 1'b1;
                        claim_id_o  <= eip_q ? best_id_q : '0;
                    end else if (cmpl_req_i) begin
                        state_q    <= CMPL;
                        cmpl_ack_o <= 1'b1;
                        cmpl_id_q  <= cmpl_id_i;
                    end
                end
                CLAIM: begin
                    state_q     <= SETTLE;
                    claim_ack_o <= 1'b0;
                    claim_id_o  <= '0;
                end
                SETTLE: begin
                    state_q <= IDLE;
                end
                CMPL: begin
                    state_q    <= IDLE;
                    cmpl_ack_o <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    claim_ack_o <= 1'b0;
                    claim_id_o  <= '0;
                    cmpl_ack_o  <= 1'b0;
                end
            endcase
        end
    end

    assign pend_o = pending_q;
    assign eip_o  = eip_q;

endmodule

// File: tb/tb_plic_target_ctrl.sv
// Directed bench for plic_target_ctrl: a transaction-timed reference model checked every cycle,
// plus literal expectations for the key scenarios. Build with PLIC_EDGE_TRIG_EN for the edge case.
module tb_plic_target_ctrl;

    localparam int NUM_IRQ  = 32;
    localparam int PRIO_BIT = 3;
    localparam int ID_WIDTH = 6;

    typedef struct packed {
        logic                v;
        logic [ID_WIDTH-1:0] id;
        logic [PRIO_BIT-1:0] pr;
    } arb_t;

    logic                clk_i = 1'b0;
    logic                rst_n_i = 1'b0;
    logic [NUM_IRQ-1:0]  src_irq_i = '0;
    logic [NUM_IRQ-1:0]  pend_o;
    logic                arb_irq_i;
    logic [ID_WIDTH-1:0] arb_id_i;
    logic [PRIO_BIT-1:0] arb_pri_i;
    logic [PRIO_BIT-1:0] threshold_i = '0;
    logic                eip_o;
    logic                claim_req_i = 1'b0;
    logic                claim_ack_o;
    logic [ID_WIDTH-1:0] claim_id_o;
    logic                cmpl_req_i = 1'b0;
    logic [ID_WIDTH-1:0] cmpl_id_i = '0;
    logic                cmpl_ack_o;
`ifdef PLIC_EDGE_TRIG_EN
    logic [NUM_IRQ-1:0]  src_edge_i = '0;
`endif

    logic [NUM_IRQ-1:0][PRIO_BIT-1:0] prio = '0;
    arb_t arb_dut;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    plic_target_ctrl #(.NUM_IRQ(NUM_IRQ), .PRIO_BIT(PRIO_BIT), .ID_WIDTH(ID_WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .src_irq_i   (src_irq_i),
`ifdef PLIC_EDGE_TRIG_EN
        .src_edge_i  (src_edge_i),
`endif
        .pend_o      (pend_o),
        .arb_irq_i   (arb_irq_i),
        .arb_id_i    (arb_id_i),
        .arb_pri_i   (arb_pri_i),
        .threshold_i (threshold_i),
        .eip_o       (eip_o),
        .claim_req_i (claim_req_i),
        .claim_ack_o (claim_ack_o),
        .claim_id_o  (claim_id_o),
        .cmpl_req_i  (cmpl_req_i),
        .cmpl_id_i   (cmpl_id_i),
        .cmpl_ack_o  (cmpl_ack_o)
    );

    // External priority arbiter: highest priority wins, lowest ID on ties, IDs start at 1.
    function automatic arb_t arb(input logic [NUM_IRQ-1:0] p,
                                 input logic [NUM_IRQ-1:0][PRIO_BIT-1:0] pri);
        arb_t r;
        r = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (p[k] && (!r.v || pri[k] > r.pr)) begin
                r.v  = 1'b1;
                r.id = ID_WIDTH'(k + 1);
                r.pr = pri[k];
            end
        end
        return r;
    endfunction

    always_comb arb_dut = arb(pend_o, prio);
    assign arb_irq_i = arb_dut.v;
    assign arb_id_i  = arb_dut.id;
    assign arb_pri_i = arb_dut.pr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state as plain bit arrays, handshake timing as cycle stamps.
    logic [NUM_IRQ-1:0]  m_pend = '0, m_insv = '0, m_prev = '0, m_trig, m_new_pend, m_new_insv;
    logic [ID_WIDTH-1:0] m_best = '0, m_claim_id = '0, m_cmpl_id = '0;
    logic                m_eip = 1'b0;
    arb_t                m_arb;
    int cyc = 0, claim_at = -10, cmpl_at = -10, free_at = 0;

    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_pend = '0; m_insv = '0; m_prev = '0; m_best = '0; m_eip = 1'b0;
            claim_at = -10; cmpl_at = -10; free_at = cyc + 1;
        end else begin
            m_arb  = arb(m_pend, prio);
            m_trig = src_irq_i;
`ifdef PLIC_EDGE_TRIG_EN
            m_trig = (src_irq_i & ~src_edge_i) | (src_irq_i & src_edge_i & ~m_prev);
`endif
            m_new_pend = m_pend | (m_trig & ~m_pend & ~m_insv);
            m_new_insv = m_insv;
            if (cyc == claim_at + 1 && int'(m_claim_id) >= 1 && int'(m_claim_id) <= NUM_IRQ) begin
                m_new_pend[int'(m_claim_id) - 1] = 1'b0;
                m_new_insv[int'(m_claim_id) - 1] = 1'b1;
            end
            if (cyc == cmpl_at + 1 && int'(m_cmpl_id) >= 1 && int'(m_cmpl_id) <= NUM_IRQ)
                m_new_insv[int'(m_cmpl_id) - 1] = 1'b0;
            if (cyc >= free_at) begin
                if (claim_req_i) begin
                    claim_at   = cyc;
                    m_claim_id = m_eip ? m_best : '0;
                    free_at    = cyc + 3;
                end else if (cmpl_req_i) begin
                    cmpl_at   = cyc;
                    m_cmpl_id = cmpl_id_i;
                    free_at   = cyc + 2;
                end
            end
            m_best = m_arb.id;
            m_eip  = m_arb.v && (m_arb.pr > threshold_i);
            m_pend = m_new_pend;
            m_insv = m_new_insv;
            m_prev = src_irq_i;
        end
        cyc++;
        #1;
        chk("m_pend", pend_o, m_pend);
        chk("m_eip", eip_o, m_eip);
        chk("m_claim_ack", claim_ack_o, cyc == claim_at + 1);
        chk("m_claim_id", claim_id_o, (cyc == claim_at + 1) ? m_claim_id : '0);
        chk("m_cmpl_ack", cmpl_ack_o, cyc == cmpl_at + 1);
    end

    task automatic do_claim(input logic [ID_WIDTH-1:0] exp_id, input string nm);
        claim_req_i = 1'b1;
        @(negedge clk_i);
        chk({nm, "_ack"}, claim_ack_o, 1);
        chk({nm, "_id"}, claim_id_o, exp_id);
        claim_req_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_cmpl(input logic [ID_WIDTH-1:0] id, input string nm);
        cmpl_req_i = 1'b1;
        cmpl_id_i  = id;
        @(negedge clk_i);
        chk({nm, "_ack"}, cmpl_ack_o, 1);
        cmpl_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_pend", pend_o, 0);
        chk("rst_outs", {eip_o, claim_ack_o, claim_id_o, cmpl_ack_o}, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Source 3, priority 5 over threshold 2.
        prio[3] = 3'd5; threshold_i = 3'd2; src_irq_i[3] = 1'b1;
        @(negedge clk_i);
        chk("t1_pend", pend_o[3], 1);
        chk("t1_eip_early", eip_o, 0);
        src_irq_i[3] = 1'b0;
        @(negedge clk_i);
        chk("t1_eip", eip_o, 1);
        do_claim(6'd4, "t1_claim");
        chk("t1_pend_clr", pend_o[3], 0);
        do_cmpl(6'd4, "t1_cmpl");

        // Priority equal to threshold: claim returns ID 0 and leaves pending alone.
        prio[1] = 3'd2; src_irq_i[1] = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("t2_eip", eip_o, 0);
        do_claim(6'd0, "t2_claim0");
        chk("t2_pend_kept", pend_o[1], 1);
        threshold_i = 3'd1; src_irq_i[1] = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t2_eip_low_thr", eip_o, 1);
        do_claim(6'd2, "t2_claim");
        do_cmpl(6'd2, "t2_cmpl");

        // Claim and complete raised together: claim served first, complete four cycles later.
        prio[5] = 3'd3; threshold_i = 3'd0; src_irq_i[5] = 1'b1;
        @(negedge clk_i);
        src_irq_i[5] = 1'b0;
        @(negedge clk_i);
        claim_req_i = 1'b1; cmpl_req_i = 1'b1; cmpl_id_i = 6'd6;
        @(negedge clk_i);
        chk("t3_claim_ack", claim_ack_o, 1);
        chk("t3_claim_id", claim_id_o, 6);
        chk("t3_cmpl_n1", cmpl_ack_o, 0);
        claim_req_i = 1'b0;
        @(negedge clk_i);
        chk("t3_cmpl_n2", cmpl_ack_o, 0);
        @(negedge clk_i);
        chk("t3_cmpl_n3", cmpl_ack_o, 0);
        @(negedge clk_i);
        chk("t3_cmpl_n4", cmpl_ack_o, 1);
        cmpl_req_i = 1'b0;
        @(negedge clk_i);

        // Level source held high re-pends after completion; bogus complete is a no-op.
        prio[0] = 3'd1; src_irq_i[0] = 1'b1;
        repeat (2) @(negedge clk_i);
        do_claim(6'd1, "t4_claim");
        chk("t4_pend_insv", pend_o[0], 0);
        cmpl_req_i = 1'b1; cmpl_id_i = 6'd1;
        @(negedge clk_i);
        chk("t4_cmpl_ack", cmpl_ack_o, 1);
        cmpl_req_i = 1'b0;
        @(negedge clk_i);
        chk("t4_pend_wait", pend_o[0], 0);
        @(negedge clk_i);
        chk("t4_repend", pend_o[0], 1);
        do_cmpl(6'd9, "t4_cmpl9");
        chk("t4_cmpl9_nochg", pend_o, 32'h1);
        src_irq_i[0] = 1'b0;
        do_claim(6'd1, "t4_claim2");
        do_cmpl(6'd1, "t4_cmpl2");

        // Reset asserted during CLAIM aborts it; source is not left in service.
        prio[2] = 3'd4; src_irq_i[2] = 1'b1;
        repeat (2) @(negedge clk_i);
        claim_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0; claim_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("t5_rst_pend", pend_o, 0);
        chk("t5_rst_outs", {eip_o, claim_ack_o, claim_id_o, cmpl_ack_o}, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("t5_repend", pend_o[2], 1);
        src_irq_i[2] = 1'b0;
        @(negedge clk_i);
        do_claim(6'd3, "t5_claim");
        do_cmpl(6'd3, "t5_cmpl");

`ifdef PLIC_EDGE_TRIG_EN
        // Edge source: second pulse while in service is dropped.
        src_edge_i[7] = 1'b1; prio[7] = 3'd3; src_irq_i[7] = 1'b1;
        @(negedge clk_i);
        src_irq_i[7] = 1'b0;
        chk("t6_pend", pend_o[7], 1);
        @(negedge clk_i);
        do_claim(6'd8, "t6_claim");
        src_irq_i[7] = 1'b1;
        @(negedge clk_i);
        src_irq_i[7] = 1'b0;
        @(negedge clk_i);
        do_cmpl(6'd8, "t6_cmpl");
        repeat (3) @(negedge clk_i);
        chk("t6_dropped", pend_o[7], 0);
`endif

        repeat (3) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
